// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-source encodings, reset vector
// and the instruction field positions decoded by the control unit.
package cpu_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode stream
// and the redirect inputs from the control unit.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc4;
    logic [5:0]        Opcode;
    logic [5:0]        func;
    logic [4:0]        Rt;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        PCSrc;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] jr_target;

    modport master (
        output imem_req, imem_addr,
        output instr, instr_pc4, Opcode, func, Rt, instr_valid,
        input  imem_rdata, instr_ready,
        input  PCSrc, br_target, j_target, jr_target
    );

    modport slave (
        input  imem_req, imem_addr,
        input  instr, instr_pc4, Opcode, func, Rt, instr_valid,
        output imem_rdata, instr_ready,
        output PCSrc, br_target, j_target, jr_target
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue for the fetch stage.
// Flush wins over push so a wrong-path return never lands.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_data,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wp] <= i_data;
    end

    assign o_data  = r_mem[r_rp];
    assign o_count = r_cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem issue, prefetch queue and PCSrc redirect.
// Wrong-path reads are dropped by epoch tag and queue flush.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 32 + ADDR_W;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_infl_pc4;
    logic              r_run;
    logic              r_infl;
    logic              r_infl_ep;
    logic              r_epoch;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc4;
    logic              w_redir;
    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [CW-1:0]     w_cnt;
    logic [CW:0]       w_occ;
    logic [EW-1:0]     w_head;
    logic [31:0]       w_instr;

    assign w_redir = (bus.PCSrc != PCSRC_SEQ);
    assign w_occ   = {1'b0, w_cnt} + (CW+1)'(r_infl);
    assign w_req   = r_run && !w_redir && (w_occ < (CW+1)'(DEPTH));
    assign w_push  = r_infl && (r_infl_ep == r_epoch) && !w_redir;
    assign w_pop   = !w_empty && bus.instr_ready;
    assign w_pc4   = r_pc + ADDR_W'(4);

    always_comb begin
        w_pc_nxt = r_pc;
        case (bus.PCSrc)
            PCSRC_BR: w_pc_nxt = {bus.br_target[ADDR_W-1:2], 2'b00};
            PCSRC_J:  w_pc_nxt = {bus.j_target[ADDR_W-1:2], 2'b00};
            PCSRC_JR: w_pc_nxt = {bus.jr_target[ADDR_W-1:2], 2'b00};
            default:  if (w_req) w_pc_nxt = w_pc4;
        endcase
    end

    // r_run delays the first request by one cycle after reset release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_run      <= 1'b0;
            r_infl     <= 1'b0;
            r_infl_ep  <= 1'b0;
            r_infl_pc4 <= '0;
            r_epoch    <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_run      <= 1'b1;
            r_infl     <= w_req;
            r_infl_pc4 <= w_pc4;
            if (w_req)   r_infl_ep <= r_epoch;
            if (w_redir) r_epoch   <= ~r_epoch;
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({bus.imem_rdata, r_infl_pc4}),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    // empty queue presents an all-zero word, which decodes as a nop
    assign w_instr         = w_empty ? 32'h0 : w_head[EW-1:ADDR_W];
    assign bus.instr       = w_instr;
    assign bus.instr_pc4   = w_empty ? '0 : w_head[ADDR_W-1:0];
    assign bus.Opcode      = w_instr[OPC_MSB:OPC_LSB];
    assign bus.func        = w_instr[FUNC_MSB:FUNC_LSB];
    assign bus.Rt          = w_instr[RT_MSB:RT_LSB];
    assign bus.instr_valid = !w_empty;
    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_req ? r_pc : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed timing scenarios
// plus a randomized run against a program-order reference model.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mem_mode = 0;

    instr_fetch_unit_if #(.ADDR_W(AW)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (mem_mode == 0) return a;
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    // instruction memory: data one cycle after an accepted request
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= memf(bus.imem_addr);
        else              bus.imem_rdata <= 32'hDEAD_BEEF;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rdy, input logic [1:0] src,
                          input logic [31:0] t);
        bus.instr_ready = rdy;
        bus.PCSrc       = src;
        bus.br_target   = (src == PCSRC_BR) ? t : 32'h0000_0BB0;
        bus.j_target    = (src == PCSRC_J)  ? t : 32'h0000_0CC0;
        bus.jr_target   = (src == PCSRC_JR) ? t : 32'h0000_0DD0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        nxt();
        nxt();
        @(negedge clk);
        n_cmp++;
        if ({bus.imem_req, bus.instr_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_req_valid got=%b exp=00",
                     {bus.imem_req, bus.instr_valid});
        end
        n_cmp++;
        if (bus.imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_addr got=%h exp=0", bus.imem_addr);
        end
        n_cmp++;
        if ({bus.instr, bus.instr_pc4} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_instr got=%h/%h exp=0",
                     bus.instr, bus.instr_pc4);
        end
        n_cmp++;
        if ({bus.Opcode, bus.func, bus.Rt} !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_fields got=%h exp=0",
                     {bus.Opcode, bus.func, bus.Rt});
        end
    endtask

    task automatic test_startup();
        mem_mode = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.imem_req !== (c >= 1)) begin
                n_bad++;
                $display("FAIL start_req c=%0d got=%b exp=%b",
                         c, bus.imem_req, c >= 1);
            end
            if (c >= 1) begin
                n_cmp++;
                if (bus.imem_addr !== 32'((c - 1) * 4)) begin
                    n_bad++;
                    $display("FAIL start_addr c=%0d got=%h exp=%h",
                             c, bus.imem_addr, (c - 1) * 4);
                end
            end
            n_cmp++;
            if (bus.instr_valid !== (c >= 3)) begin
                n_bad++;
                $display("FAIL start_valid c=%0d got=%b exp=%b",
                         c, bus.instr_valid, c >= 3);
            end
            if (c >= 3) begin
                n_cmp++;
                if ({bus.instr, bus.instr_pc4} !==
                    {32'((c - 3) * 4), 32'((c - 2) * 4)}) begin
                    n_bad++;
                    $display("FAIL start_pc4 c=%0d got=%h/%h exp=%h/%h",
                             c, bus.instr, bus.instr_pc4,
                             (c - 3) * 4, (c - 2) * 4);
                end
            end
            nxt();
        end
    endtask

    task automatic test_full();
        logic [31:0] addrs[$];
        mem_mode = 0;
        do_reset();
        set_in(1'b0, PCSRC_SEQ, 32'h0);
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (bus.imem_req) addrs.push_back(bus.imem_addr);
            if (c == 10) begin
                n_cmp++;
                if (bus.imem_req !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_req got=%b exp=0", bus.imem_req);
                end
            end
            nxt();
        end
        n_cmp++;
        if (addrs.size() != DEPTH) begin
            n_bad++;
            $display("FAIL full_nreq got=%0d exp=%0d", addrs.size(), DEPTH);
        end
        for (int i = 0; i < addrs.size(); i++) begin
            n_cmp++;
            if (addrs[i] !== 32'(i * 4)) begin
                n_bad++;
                $display("FAIL full_addr i=%0d got=%h exp=%h",
                         i, addrs[i], i * 4);
            end
        end
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.instr_valid, bus.instr} !== {1'b1, 32'(k * 4)}) begin
                n_bad++;
                $display("FAIL drain k=%0d got=%b/%h exp=1/%h",
                         k, bus.instr_valid, bus.instr, k * 4);
            end
            nxt();
        end
    endtask

    task automatic test_branch();
        bit found = 0;
        mem_mode = 0;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.instr_valid && bus.instr_pc4 == 32'h14) found = 1;
            else nxt();
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL br_setup got=timeout exp=head 0x10");
        end
        set_in(1'b1, PCSRC_BR, 32'h40);
        @(negedge clk);
        n_cmp++;
        if ({bus.imem_req, bus.instr_valid} !== 2'b01) begin
            n_bad++;
            $display("FAIL br_cycle got=%b exp=01",
                     {bus.imem_req, bus.instr_valid});
        end
        nxt();
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        for (int d = 1; d <= 3; d++) begin
            @(negedge clk);
            if (d < 3) begin
                n_cmp++;
                if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !==
                    {2'b01, 32'h40 + 32'((d - 1) * 4)}) begin
                    n_bad++;
                    $display("FAIL br_after d=%0d got=%b%b/%h exp=01/%h",
                             d, bus.instr_valid, bus.imem_req,
                             bus.imem_addr, 32'h40 + (d - 1) * 4);
                end
            end else begin
                n_cmp++;
                if ({bus.instr_valid, bus.instr, bus.instr_pc4} !==
                    {1'b1, 32'h40, 32'h44}) begin
                    n_bad++;
                    $display("FAIL br_target got=%b/%h/%h exp=1/40/44",
                             bus.instr_valid, bus.instr, bus.instr_pc4);
                end
            end
            nxt();
        end
    endtask

    task automatic test_jump();
        mem_mode = 0;
        do_reset();
        repeat (6) nxt();
        set_in(1'b1, PCSRC_JR, 32'h103);
        @(negedge clk);
        n_cmp++;
        if (bus.imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL jr_cycle_req got=%b exp=0", bus.imem_req);
        end
        nxt();
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
            n_bad++;
            $display("FAIL jr_req got=%b/%h exp=1/100",
                     bus.imem_req, bus.imem_addr);
        end
        nxt();
        set_in(1'b1, PCSRC_J, 32'h200);
        @(negedge clk);
        n_cmp++;
        if ({bus.imem_req, bus.instr_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL j_cycle got=%b exp=00",
                     {bus.imem_req, bus.instr_valid});
        end
        nxt();
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        for (int d = 1; d <= 3; d++) begin
            @(negedge clk);
            if (d == 1) begin
                n_cmp++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) begin
                    n_bad++;
                    $display("FAIL j_req got=%b/%h exp=1/200",
                             bus.imem_req, bus.imem_addr);
                end
            end
            n_cmp++;
            if (d < 3 && bus.instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL j_bubble d=%0d got=%h exp=invalid",
                         d, bus.instr);
            end else if (d == 3 && {bus.instr_valid, bus.instr_pc4,
                                    bus.instr} !==
                         {1'b1, 32'h204, 32'h200}) begin
                n_bad++;
                $display("FAIL j_target got=%b/%h/%h exp=1/204/200",
                         bus.instr_valid, bus.instr_pc4, bus.instr);
            end
            nxt();
        end
    endtask

    task automatic test_back_to_back();
        mem_mode = 0;
        do_reset();
        repeat (6) nxt();
        set_in(1'b1, PCSRC_BR, 32'h300);
        nxt();
        set_in(1'b1, PCSRC_JR, 32'h501);
        @(negedge clk);
        n_cmp++;
        if ({bus.imem_req, bus.instr_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_cycle got=%b exp=00",
                     {bus.imem_req, bus.instr_valid});
        end
        nxt();
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h500}) begin
            n_bad++;
            $display("FAIL b2b_req got=%b/%h exp=1/500",
                     bus.imem_req, bus.imem_addr);
        end
        nxt();
        nxt();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.instr_valid, bus.instr} !==
                {1'b1, 32'h500 + 32'(k * 4)}) begin
                n_bad++;
                $display("FAIL b2b_seq k=%0d got=%b/%h exp=1/%h",
                         k, bus.instr_valid, bus.instr, 32'h500 + k * 4);
            end
            nxt();
        end
    endtask

    task automatic test_reset_full();
        mem_mode = 0;
        do_reset();
        set_in(1'b0, PCSRC_SEQ, 32'h0);
        repeat (10) nxt();
        @(negedge clk);
        n_cmp++;
        if ({bus.instr_valid, bus.imem_req} !== 2'b10) begin
            n_bad++;
            $display("FAIL rf_full got=%b exp=10",
                     {bus.instr_valid, bus.imem_req});
        end
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr,
             bus.instr_pc4, bus.Opcode, bus.func, bus.Rt} !== '0) begin
            n_bad++;
            $display("FAIL rf_zero got=%b%b/%h/%h/%h exp=all 0",
                     bus.imem_req, bus.instr_valid, bus.imem_addr,
                     bus.instr, bus.instr_pc4);
        end
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        nxt();
        @(negedge clk);
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL rf_refetch got=%b/%h exp=1/0",
                     bus.imem_req, bus.imem_addr);
        end
        nxt();
        nxt();
        @(negedge clk);
        n_cmp++;
        if ({bus.instr_valid, bus.instr, bus.instr_pc4} !==
            {1'b1, 32'h0, 32'h4}) begin
            n_bad++;
            $display("FAIL rf_first got=%b/%h/%h exp=1/0/4",
                     bus.instr_valid, bus.instr, bus.instr_pc4);
        end
        nxt();
    endtask

    task automatic test_wrap();
        logic [31:0] exp = 32'hFFFF_FFF4;
        int pops = 0;
        bit seen = 0;
        mem_mode = 0;
        do_reset();
        set_in(1'b1, PCSRC_J, exp);
        nxt();
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        for (int i = 0; i < 30 && pops < 5; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                n_cmp++;
                if ({bus.instr, bus.instr_pc4} !== {exp, exp + 32'h4}) begin
                    n_bad++;
                    $display("FAIL wrap_seq got=%h/%h exp=%h/%h",
                             bus.instr, bus.instr_pc4, exp, exp + 32'h4);
                end
                exp = exp + 32'h4;
                pops++;
            end
            nxt();
        end
        n_cmp++;
        if (pops != 5) begin
            n_bad++;
            $display("FAIL wrap_count got=%0d exp=5", pops);
        end
        set_in(1'b1, PCSRC_BR, 32'h80);
        @(negedge clk);
        if (bus.instr_valid) exp = exp + 32'h4;
        nxt();
        set_in(1'b1, PCSRC_SEQ, 32'h0);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.instr_valid) seen = 1;
            if (!seen) nxt();
        end
        n_cmp++;
        if ({seen, bus.instr, bus.instr_pc4} !== {1'b1, 32'h80, 32'h84}) begin
            n_bad++;
            $display("FAIL wrap_redir got=%b/%h/%h exp=1/80/84",
                     seen, bus.instr, bus.instr_pc4);
        end
        nxt();
    endtask

    task automatic test_random();
        logic [31:0] exp = 32'h0;
        logic [31:0] w;
        logic [31:0] tgt;
        logic [1:0]  src;
        logic        rdy;
        int          pops = 0;
        mem_mode = 1;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            rdy = ($urandom_range(0, 9) < 7);
            src = ($urandom_range(0, 99) < 6) ?
                  2'($urandom_range(1, 3)) : PCSRC_SEQ;
            tgt = $urandom;
            set_in(rdy, src, tgt);
            @(negedge clk);
            w = memf(exp);
            if (bus.instr_valid) begin
                n_cmp++;
                if ({bus.instr, bus.instr_pc4} !== {w, exp + 32'h4}) begin
                    n_bad++;
                    $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h",
                             cyc, bus.instr, bus.instr_pc4, w, exp + 32'h4);
                end
                n_cmp++;
                if ({bus.Opcode, bus.func, bus.Rt} !==
                    {w[31:26], w[5:0], w[20:16]}) begin
                    n_bad++;
                    $display("FAIL rnd_fields cyc=%0d got=%h exp=%h", cyc,
                             {bus.Opcode, bus.func, bus.Rt},
                             {w[31:26], w[5:0], w[20:16]});
                end
                if (rdy) begin
                    exp = exp + 32'h4;
                    pops++;
                end
            end else begin
                n_cmp++;
                if ({bus.instr, bus.instr_pc4, bus.Opcode} !== '0) begin
                    n_bad++;
                    $display("FAIL rnd_empty cyc=%0d got=%h/%h exp=0",
                             cyc, bus.instr, bus.instr_pc4);
                end
            end
            if (src != PCSRC_SEQ) begin
                n_cmp++;
                if (bus.imem_req !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rnd_redir_req cyc=%0d got=1 exp=0", cyc);
                end
                exp = {tgt[31:2], 2'b00};
            end
            nxt();
        end
        n_cmp++;
        if (pops < 200) begin
            n_bad++;
            $display("FAIL rnd_throughput got=%0d exp>=200", pops);
        end
    endtask

    initial begin
        bus.instr_ready = 1'b1;
        bus.PCSrc       = PCSRC_SEQ;
        bus.br_target   = '0;
        bus.j_target    = '0;
        bus.jr_target   = '0;
        test_reset();
        test_startup();
        test_full();
        test_branch();
        test_jump();
        test_back_to_back();
        test_reset_full();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
